// File: rtl/pipe_stage_skid_reg.sv
// rtl/pipe_stage_skid_reg.sv - MEM/WB pipeline stage register with 2-entry skid buffer, flush and stall counter
//
// Purpose:
//   Carries MEM/WB control fields and a data payload between pipe stages
//   over a valid/ready handshake. A main entry drives the outputs and a skid
//   entry absorbs one extra beat, so the stage sustains one entry per cycle
//   under backpressure without in_ready depending on out_ready.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               synchronous flush: empties the stage, drops same-cycle input
//   in_valid/in_ready   upstream handshake
//   in_mem/in_wb/in_data    upstream entry fields
//   out_valid/out_ready downstream handshake
//   out_mem/out_wb/out_data entry fields, all zero while out_valid=0
//   stall_cnt           saturating count of cycles with out_valid & !out_ready
module pipe_stage_skid_reg #(
    parameter int MEM_W  = 12,
    parameter int WB_W   = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MEM_W-1:0]  in_mem,
    input  logic [WB_W-1:0]   in_wb,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MEM_W-1:0]  out_mem,
    output logic [WB_W-1:0]   out_wb,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t state;

    logic [MEM_W-1:0]  main_mem,  skid_mem;
    logic [WB_W-1:0]   main_wb,   skid_wb;
    logic [DATA_W-1:0] main_data, skid_data;

    logic in_fire;
    logic out_fire;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Handshake flags are pure decodes of the state register.
    assign in_ready  = (state != S_FULL);
    assign out_valid = (state != S_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Main entry is zeroed whenever it stops holding a valid entry, so the
    // outputs can be driven straight from it and still read as a bubble.
    assign out_mem  = main_mem;
    assign out_wb   = main_wb;
    assign out_data = main_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_EMPTY;
            main_mem  <= '0;
            main_wb   <= '0;
            main_data <= '0;
            skid_mem  <= '0;
            skid_wb   <= '0;
            skid_data <= '0;
        end else if (flush) begin
            // Flush wins over everything; any same-cycle input is discarded.
            state     <= S_EMPTY;
            main_mem  <= '0;
            main_wb   <= '0;
            main_data <= '0;
            skid_mem  <= '0;
            skid_wb   <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        main_mem  <= in_mem;
                        main_wb   <= in_wb;
                        main_data <= in_data;
                        state     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_mem  <= in_mem;
                        main_wb   <= in_wb;
                        main_data <= in_data;
                    end else if (in_fire) begin
                        // Downstream stalled: park the new entry behind main.
                        skid_mem  <= in_mem;
                        skid_wb   <= in_wb;
                        skid_data <= in_data;
                        state     <= S_FULL;
                    end else if (out_fire) begin
                        main_mem  <= '0;
                        main_wb   <= '0;
                        main_data <= '0;
                        state     <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        main_mem  <= skid_mem;
                        main_wb   <= skid_wb;
                        main_data <= skid_data;
                        skid_mem  <= '0;
                        skid_wb   <= '0;
                        skid_data <= '0;
                        state     <= S_BUSY;
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    main_mem  <= '0;
                    main_wb   <= '0;
                    main_data <= '0;
                    skid_mem  <= '0;
                    skid_wb   <= '0;
                    skid_data <= '0;
                end
            endcase
        end
    end

    // Counts backpressure cycles independent of flush; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb/tb_pipe_stage_skid_reg.sv - scoreboard bench for pipe_stage_skid_reg
module tb_pipe_stage_skid_reg;

    localparam int MEM_W  = 12;
    localparam int WB_W   = 10;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [MEM_W-1:0]  m;
        logic [WB_W-1:0]   w;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [MEM_W-1:0]  in_mem;
    logic [WB_W-1:0]   in_wb;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [MEM_W-1:0]  out_mem;
    logic [WB_W-1:0]   out_wb;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(
        .MEM_W (MEM_W),
        .WB_W  (WB_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mem   (in_mem),
        .in_wb    (in_wb),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mem  (out_mem),
        .out_wb   (out_wb),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    // Reference model: the stage is a FIFO of at most two entries.
    ent_t exp_q[$];
    int   occ     = 0;
    int   stall_m = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   n_deliv = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT completes a transfer.
    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {10'd0, out_mem, out_wb, out_data}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_mem", 64'(out_mem), 64'(e.m));
                    chk("out_wb", 64'(out_wb), 64'(e.w));
                    chk("out_data", 64'(out_data), 64'(e.d));
                    n_deliv++;
                end
            end
        end
    end

    task automatic check_state();
        chk("in_ready", 64'(in_ready), 64'(occ < 2));
        chk("out_valid", 64'(out_valid), 64'(occ > 0));
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        if (occ == 0)
            chk("bubble", {10'd0, out_mem, out_wb, out_data}, 64'd0);
    endtask

    task automatic step(input logic v, input ent_t e, input logic ordy, input logic fl);
        logic inf, outf;
        @(negedge clk);
        check_state();
        in_valid  = v;
        in_mem    = e.m;
        in_wb     = e.w;
        in_data   = e.d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        inf  = v && (occ < 2);
        outf = (occ > 0) && ordy;
        if (occ > 0 && !ordy && stall_m < STALL_MAX)
            stall_m++;
        if (fl) begin
            occ = 0;
            exp_q.delete();
        end else begin
            if (inf)
                exp_q.push_back(e);
            occ = occ + int'(inf) - int'(outf);
        end
    endtask

    function automatic ent_t rand_ent();
        ent_t e;
        logic [31:0] a, b, c;
        a = $urandom;
        b = $urandom;
        c = $urandom;
        e.m = a[MEM_W-1:0];
        e.w = b[WB_W-1:0];
        e.d = c;
        return e;
    endfunction

    ent_t z, d0, d1, t1;
    int   base;

    initial begin
        z = '0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mem = '0; in_wb = '0; in_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_fields", {10'd0, out_mem, out_wb, out_data}, 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        rst = 1'b0;

        // 1: single entry, 1-cycle latency
        t1.m = 12'hA5A; t1.w = 10'h155; t1.d = 32'h1234;
        step(1'b1, t1, 1'b1, 1'b0);
        step(1'b0, z, 1'b1, 1'b0);
        step(1'b0, z, 1'b1, 1'b0);

        // 2: stream of 8 at full throughput
        base = n_deliv;
        for (int i = 0; i < 8; i++) step(1'b1, rand_ent(), 1'b1, 1'b0);
        step(1'b0, z, 1'b1, 1'b0);
        step(1'b0, z, 1'b1, 1'b0);
        chk("stream_count", 64'(n_deliv - base), 64'd8);
        chk("stream_stall", 64'(stall_cnt), 64'd0);

        // 3: backpressure fills skid, then drains in order
        d0 = rand_ent();
        d1 = rand_ent();
        step(1'b1, d0, 1'b0, 1'b0);
        step(1'b1, d1, 1'b0, 1'b0);
        step(1'b0, z, 1'b0, 1'b0);
        chk("full_head", {10'd0, out_mem, out_wb, out_data}, {10'd0, d0});
        for (int i = 0; i < 3; i++) step(1'b0, z, 1'b1, 1'b0);

        // 4: flush while FULL with a valid input
        step(1'b1, rand_ent(), 1'b0, 1'b0);
        step(1'b1, rand_ent(), 1'b0, 1'b0);
        step(1'b1, rand_ent(), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, z, 1'b1, 1'b0);

        // Random traffic with occasional flush
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0, rand_ent(), ($urandom % 3) != 0, ($urandom % 50) == 0);
        for (int i = 0; i < 4; i++) step(1'b0, z, 1'b1, 1'b0);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        // 6: asynchronous reset while FULL
        step(1'b1, rand_ent(), 1'b0, 1'b0);
        step(1'b1, rand_ent(), 1'b0, 1'b0);
        step(1'b0, z, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_fields", {10'd0, out_mem, out_wb, out_data}, 64'd0);
        chk("arst_stall", 64'(stall_cnt), 64'd0);
        occ = 0;
        stall_m = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        base = n_deliv;
        step(1'b1, rand_ent(), 1'b1, 1'b0);
        step(1'b0, z, 1'b1, 1'b0);
        chk("post_rst_latency", 64'(n_deliv - base), 64'd1);

        // 5: stall counter saturation
        step(1'b1, rand_ent(), 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) step(1'b0, z, 1'b0, 1'b0);
        @(negedge clk);
        chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
        for (int i = 0; i < 3; i++) step(1'b0, z, 1'b1, 1'b0);
        chk("final_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
